potential_update_scheduler: RTL

POTENTIAL_UPDATE_SCHEDULER -- requirements
Module: potential_update_scheduler

---
 rtl/potential_update_scheduler_pkg.sv | 17 +
 rtl/potential_update_scheduler.sv | 130 +++++++++++++
 2 files changed

// File: rtl/potential_update_scheduler_pkg.sv
// Shared types for the potential update scheduler.
// FSM state encoding and float constants.
package potential_update_scheduler_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_WAIT,
    S_ADD,
    S_WRITE,
    S_SPIKE,
    S_DONE
  } state_e;

  localparam logic [31:0] FLOAT_ZERO = 32'h0;

endpackage

// File: rtl/potential_update_scheduler.sv
// Sequences per-neuron potential updates through an external adder.
// One sweep visits every neuron, writes back, and emits spikes.
module potential_update_scheduler
  import potential_update_scheduler_pkg::*;
#(
  parameter int NUM_NEURONS = 32,
  parameter int ADDR_W      = 5
) (
  input  logic              CLK,
  input  logic              RESET_N,
  input  logic              timestep_start,
  input  logic [31:0]       v_threshold,
  output logic              pot_rd_en,
  output logic [ADDR_W-1:0] pot_rd_addr,
  input  logic [31:0]       pot_rd_data,
  output logic              wt_rd_en,
  output logic [ADDR_W-1:0] wt_rd_addr,
  input  logic [31:0]       wt_rd_data,
  output logic              add_clear,
  output logic [31:0]       add_threshold,
  output logic [31:0]       add_weight,
  output logic [31:0]       add_decayed,
  input  logic [31:0]       add_final,
  input  logic              add_spike,
  output logic              pot_wr_en,
  output logic [ADDR_W-1:0] pot_wr_addr,
  output logic [31:0]       pot_wr_data,
  output logic              spike_valid,
  output logic [ADDR_W-1:0] spike_id,
  input  logic              spike_ready,
  output logic              busy,
  output logic              done,
  output logic              overrun
);

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_NEURONS - 1);

  state_e            state;
  state_e            state_nx;
  logic [ADDR_W-1:0] idx;
  logic [31:0]       thr_q;
  logic [31:0]       pot_q;
  logic [31:0]       wt_q;
  logic [31:0]       sum_q;
  logic              spike_q;
  logic              accept;
  logic              advance;
  logic              last;

  assign last = (idx == LAST_IDX);

  // Start is only honoured from IDLE; DONE still counts as busy.
  assign accept  = RESET_N && timestep_start && (state == S_IDLE);
  assign overrun = RESET_N && timestep_start && (state != S_IDLE);

  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      state   <= S_IDLE;
      idx     <= '0;
      thr_q   <= FLOAT_ZERO;
      pot_q   <= FLOAT_ZERO;
      wt_q    <= FLOAT_ZERO;
      sum_q   <= FLOAT_ZERO;
      spike_q <= 1'b0;
    end else begin
      state <= state_nx;
      if (accept) begin
        idx   <= '0;
        thr_q <= v_threshold;
      end else if (advance && !last) begin
        idx <= idx + 1'b1;
      end
      if (state == S_WAIT) begin
        pot_q <= pot_rd_data;
        wt_q  <= wt_rd_data;
      end
      if (state == S_ADD) begin
        sum_q   <= add_final;
        spike_q <= add_spike;
      end
    end
  end

  always_comb begin
    state_nx = state;
    advance  = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (accept) state_nx = S_FETCH;
      end
      S_FETCH: state_nx = S_WAIT;
      S_WAIT:  state_nx = S_ADD;
      S_ADD:   state_nx = S_WRITE;
      S_WRITE: begin
        if (spike_q) begin
          state_nx = S_SPIKE;
        end else begin
          advance  = 1'b1;
          state_nx = last ? S_DONE : S_FETCH;
        end
      end
      S_SPIKE: begin
        if (spike_ready) begin
          advance  = 1'b1;
          state_nx = last ? S_DONE : S_FETCH;
        end
      end
      S_DONE:  state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  assign add_clear     = accept;
  assign pot_rd_en     = (state == S_FETCH);
  assign wt_rd_en      = (state == S_FETCH);
  assign pot_rd_addr   = idx;
  assign wt_rd_addr    = idx;
  assign add_threshold = thr_q;
  assign add_weight    = wt_q;
  assign add_decayed   = pot_q;
  assign pot_wr_en     = (state == S_WRITE);
  assign pot_wr_addr   = idx;
  // A spiking neuron is reset to zero rather than keeping its sum.
  assign pot_wr_data   = spike_q ? FLOAT_ZERO : sum_q;
  assign spike_valid   = (state == S_SPIKE);
  assign spike_id      = idx;
  assign busy          = (state != S_IDLE);
  assign done          = (state == S_DONE);

endmodule
